// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared types and constants for the instruction-fetch stage.
//   FETCH_FIFO_DEPTH : default prefetch depth (also the bus credit limit)
//   fetch_entry_t    : one prefetch entry {pc, instr, err}
//   align_pc()       : clears the low address bits of a fetch target
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int FETCH_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    // Forces the low 'low_bits' bits of an address to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr, input int low_bits);
        logic [31:0] mask;
        mask = (32'h1 << low_bits) - 32'h1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request/grant/rvalid bus.
//   instr_req    : request (master -> slave), held until instr_gnt
//   instr_addr   : word-aligned address (master -> slave)
//   instr_gnt    : request accepted this cycle (slave -> master)
//   instr_rvalid : response valid, in request order (slave -> master)
//   instr_rdata  : response data (slave -> master)
//   instr_err    : response error, qualified by instr_rvalid (slave -> master)
// -----------------------------------------------------------------------------
interface if_stage_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );

endinterface

// File: rtl/if_stage_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t. Clear wins over a same-cycle
// push or pop. Head is read combinationally from storage.
//   clk, reset : clock, synchronous active-high reset
//   i_push     : write i_entry (ignored when full or clearing)
//   i_entry    : entry to write
//   i_pop      : drop the head entry (ignored when empty or clearing)
//   i_clear    : empty the FIFO at the next edge
//   o_head     : current head entry (undefined when o_empty)
//   o_full     : FIFO holds DEPTH entries
//   o_empty    : FIFO holds no entries
//   o_count    : number of entries held
// -----------------------------------------------------------------------------
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter  int DEPTH = FETCH_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  fetch_entry_t  i_entry,
    input  logic          i_pop,
    input  logic          i_clear,
    output fetch_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full  & ~i_clear;
    assign w_do_pop  = i_pop  & ~o_empty & ~i_clear;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the fetch PC, drives the instruction bus under
// a credit limit, buffers responses in a prefetch FIFO and presents
// {pc, instr, error} to decode. Redirects flush the FIFO, restart fetch at the
// new target and discard responses still in flight.
//   clk, reset        : clock, synchronous active-high reset
//   boot_addr         : fetch address loaded at reset
//   bus               : instruction-memory bus (master side)
//   redirect_en/_pc   : flow change pulse and new target
//   stall_F           : suppress new requests
//   ready_id          : decode accepts the presented entry
//   pc_id             : PC of the presented entry
//   instr_payload     : presented instruction word (0 on fetch fault)
//   instr_value       : presented entry valid
//   instr_fetch_error : presented entry is a fetch fault
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter int FIFO_DEPTH     = FETCH_FIFO_DEPTH,
    parameter int RESET_PC_ALIGN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] boot_addr,
    if_stage_if.master  bus,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall_F,
    input  logic        ready_id,
    output logic [31:0] pc_id,
    output logic [31:0] instr_payload,
    output logic        instr_value,
    output logic        instr_fetch_error
);

    localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic          r_hold;
    logic [31:0]   r_hold_addr;
    logic          r_hold_stale;

    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_value;
    logic          w_pop;
    logic [CW:0]   w_inflight;
    logic          w_issue_new;
    logic          w_gnt;
    logic          w_gnt_stale;
    logic          w_late_stale;
    logic          w_drop;
    logic          w_push;
    logic          w_discard_dec;
    logic [CW-1:0] w_outst_next;

    // Decode handshake. A redirect hides the head so nothing is popped while
    // the FIFO is being flushed.
    assign w_value = ~w_fifo_empty & ~redirect_en;
    assign w_pop   = w_value & ready_id;

    // Credit: requests in flight plus buffered entries, with this cycle's pop
    // already freeing its slot so a zero-wait bus streams one word per cycle.
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_fifo_count} - (CW + 1)'(w_pop);
    assign w_issue_new = ~r_hold & (w_inflight < LIMIT) & ~stall_F & ~redirect_en;

    // A request left un-granted is held with its original address, even if a
    // redirect or stall arrives while it waits.
    assign bus.instr_req  = ~reset & (r_hold | w_issue_new);
    assign bus.instr_addr = r_hold ? r_hold_addr : r_fetch_pc;

    assign w_gnt        = bus.instr_req & bus.instr_gnt;
    assign w_late_stale = w_gnt & r_hold & r_hold_stale;
    assign w_gnt_stale  = (w_gnt & redirect_en) | w_late_stale;
    assign w_outst_next = r_outstanding + CW'(w_gnt) - CW'(bus.instr_rvalid);

    assign w_discard_dec = bus.instr_rvalid & (r_discard != '0);
    assign w_drop        = bus.instr_rvalid & (redirect_en | (r_discard != '0));
    assign w_push        = bus.instr_rvalid & ~w_drop;

    // NOTE: every field gets a default before conditional updates, so no
    // latch is inferred; a faulting fetch keeps the zero payload.
    always_comb begin
        w_push_entry    = '0;
        w_push_entry.pc = r_resp_pc;
        if (!bus.instr_err) begin
            w_push_entry.instr = bus.instr_rdata;
        end
        w_push_entry.err = bus.instr_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= align_pc(boot_addr, RESET_PC_ALIGN);
            r_resp_pc     <= align_pc(boot_addr, RESET_PC_ALIGN);
            r_outstanding <= '0;
            r_discard     <= '0;
            r_hold        <= 1'b0;
            r_hold_addr   <= '0;
            r_hold_stale  <= 1'b0;
        end else begin
            r_outstanding <= w_outst_next;

            // Everything still in flight after this cycle belongs to the old
            // path; a held request granted later is added at grant time.
            if (redirect_en) begin
                r_discard <= w_outst_next;
            end else begin
                r_discard <= r_discard - CW'(w_discard_dec) + CW'(w_late_stale);
            end

            if (redirect_en) begin
                r_fetch_pc <= align_pc(redirect_pc, RESET_PC_ALIGN);
            end else if (w_gnt && !w_gnt_stale) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (redirect_en) begin
                r_resp_pc <= align_pc(redirect_pc, RESET_PC_ALIGN);
            end else if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end

            r_hold      <= bus.instr_req & ~bus.instr_gnt;
            r_hold_addr <= bus.instr_addr;
            if (bus.instr_req && !bus.instr_gnt) begin
                r_hold_stale <= redirect_en | (r_hold & r_hold_stale);
            end else begin
                r_hold_stale <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (redirect_en),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign instr_value       = w_value;
    assign pc_id             = w_fifo_empty ? '0 : w_head.pc;
    assign instr_payload     = w_fifo_empty ? '0 : w_head.instr;
    assign instr_fetch_error = ~w_fifo_empty & w_head.err;

    a_rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (reset) bus.instr_rvalid |-> (r_outstanding != '0));

    a_discard_bounded: assert property (
        @(posedge clk) disable iff (reset) r_discard <= r_outstanding);

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Bench for if_stage. A memory responder returns words in request order with a
// configurable latency; a reference stream model expects decode to see
// consecutive word addresses from the last reset/redirect target, each carrying
// the memory word at that address (or a zero payload with error flag set).
// -----------------------------------------------------------------------------
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int DEPTH = FETCH_FIFO_DEPTH;

    logic        clk;
    logic        reset;
    logic [31:0] boot_addr;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stall_F;
    logic        ready_id;
    logic [31:0] pc_id;
    logic [31:0] instr_payload;
    logic        instr_value;
    logic        instr_fetch_error;

    if_stage_if bus ();

    if_stage #(
        .FIFO_DEPTH     (DEPTH),
        .RESET_PC_ALIGN (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .boot_addr         (boot_addr),
        .bus               (bus),
        .redirect_en       (redirect_en),
        .redirect_pc       (redirect_pc),
        .stall_F           (stall_F),
        .ready_id          (ready_id),
        .pc_id             (pc_id),
        .instr_payload     (instr_payload),
        .instr_value       (instr_value),
        .instr_fetch_error (instr_fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } resp_t;

    resp_t       pend[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          gnt_pct    = 100;
    int          rv_pct     = 100;
    int          delay_min  = 0;
    int          delay_max  = 0;
    logic        force_gnt0 = 1'b0;
    logic        chk_addr   = 1'b0;
    logic        rand_err   = 1'b0;
    logic        reset_prev = 1'b0;
    logic [31:0] salt;
    logic [31:0] err_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          pops       = 0;
    int          grants     = 0;
    int          gaps       = 0;
    int          err_pops   = 0;
    logic        seen_value = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h2545_F491) ^ salt;
        return (a == err_addr) || (rand_err && (h[31:29] == 3'b101));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: drive bus inputs, sample outputs 1ns later, advance to the
    // next falling edge. Caller sets redirect/ready/stall/reset beforehand.
    task automatic cycle();
        resp_t r;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata  = '0;
        bus.instr_err    = 1'b0;
        if (reset) begin
            pend.delete();
        end else if (pend.size() != 0 && pend[0].ready <= cyc &&
                     int'($urandom_range(99)) < rv_pct) begin
            r = pend.pop_front();
            bus.instr_rvalid = 1'b1;
            bus.instr_rdata  = mem_word(r.addr);
            bus.instr_err    = is_err(r.addr);
        end
        bus.instr_gnt = force_gnt0 ? 1'b0 : (int'($urandom_range(99)) < gnt_pct);
        #1;
        if (reset) begin
            if (reset_prev) begin
                check("reset_req", bus.instr_req, 0);
                check("reset_value", instr_value, 0);
                check("reset_pc_id", pc_id, 0);
                check("reset_payload", instr_payload, 0);
                check("reset_err", instr_fetch_error, 0);
            end
        end else begin
            if (bus.instr_req && bus.instr_gnt) begin
                grants++;
                check("addr_aligned", bus.instr_addr & 32'h3, 0);
                if (chk_addr) begin
                    check("fetch_addr", bus.instr_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                r.addr  = bus.instr_addr;
                r.ready = cyc + 1 + delay_min + int'($urandom_range(delay_max - delay_min));
                pend.push_back(r);
            end
            if (redirect_en) begin
                check("value_in_redirect", instr_value, 0);
            end
            if (instr_value && ready_id) begin
                check("pc_id", pc_id, exp_pc);
                check("payload", instr_payload, is_err(exp_pc) ? 32'h0 : mem_word(exp_pc));
                check("fetch_error", instr_fetch_error, is_err(exp_pc));
                if (instr_fetch_error) err_pops++;
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (instr_value) seen_value = 1'b1;
            else if (seen_value) gaps++;
        end
        @(posedge clk);
        if (reset) begin
            exp_pc    = boot_addr & ~32'h3;
            exp_fetch = boot_addr & ~32'h3;
        end else if (redirect_en) begin
            exp_pc = redirect_pc & ~32'h3;
        end
        reset_prev = reset;
        cyc++;
        @(negedge clk);
        redirect_en = 1'b0;
    endtask

    initial begin
        int          p0;
        logic [31:0] old_addr;

        salt             = $urandom;
        err_addr         = 32'h8000_0008;
        reset            = 1'b1;
        boot_addr        = 32'h8000_0002;
        redirect_en      = 1'b0;
        redirect_pc      = '0;
        stall_F          = 1'b0;
        ready_id         = 1'b1;
        bus.instr_gnt    = 1'b0;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata  = '0;
        bus.instr_err    = 1'b0;
        @(negedge clk);

        // Zero-wait streaming from boot_addr, error on 0x8000_0008.
        chk_addr = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        p0 = pops;
        gaps = 0;
        seen_value = 1'b0;
        repeat (24) cycle();
        check("a_pops", pops - p0, 22);
        check("a_value_gaps", gaps, 0);
        check("a_err_entries", err_pops, 1);

        // Decode stalled: credit limit bounds issue, head holds.
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        ready_id = 1'b0;
        grants = 0;
        repeat (10) cycle();
        check("b_grants_at_limit", grants, DEPTH);
        check("b_value_held", instr_value, 1);
        check("b_pc_held", pc_id, 32'h8000_0000);
        ready_id = 1'b1;
        p0 = pops;
        repeat (12) cycle();
        check("b_resume_progress", (pops - p0) >= 8, 1);

        // Redirect with two responses in flight.
        chk_addr  = 1'b0;
        delay_min = 3;
        delay_max = 3;
        for (int i = 0; i < 30; i++) begin
            if (pend.size() == 2) break;
            cycle();
        end
        check("c_two_outstanding", pend.size(), 2);
        redirect_pc = 32'h0000_1000;
        redirect_en = 1'b1;
        p0 = pops;
        cycle();
        repeat (15) cycle();
        check("c_progress_after_redirect", (pops - p0) >= 2, 1);

        // Grant withheld for five cycles with a redirect in the third.
        delay_min = 0;
        delay_max = 0;
        repeat (6) cycle();
        force_gnt0 = 1'b1;
        old_addr = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                redirect_pc = 32'h0000_1000;
                redirect_en = 1'b1;
            end
            #1;
            check("d_req_held", bus.instr_req, 1);
            if (i == 0) old_addr = bus.instr_addr;
            else check("d_addr_held", bus.instr_addr, old_addr);
            cycle();
        end
        force_gnt0 = 1'b0;
        #1;
        check("d_stale_req", bus.instr_req, 1);
        check("d_stale_addr", bus.instr_addr, old_addr);
        cycle();
        #1;
        check("d_new_req", bus.instr_req, 1);
        check("d_new_addr", bus.instr_addr, 32'h0000_1000);
        p0 = pops;
        repeat (12) cycle();
        check("d_progress", (pops - p0) >= 4, 1);

        // Reset with one response in flight and one buffered.
        delay_min = 2;
        delay_max = 2;
        ready_id  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pend.size() == 1 && instr_value) break;
            cycle();
        end
        check("e_setup", {pend.size() == 1, instr_value}, 2'b11);
        boot_addr = 32'h0000_0F0A;
        reset = 1'b1;
        cycle();
        cycle();
        reset    = 1'b0;
        ready_id = 1'b1;
        chk_addr = 1'b1;
        p0 = pops;
        repeat (12) cycle();
        check("e_restart_progress", (pops - p0) >= 4, 1);

        // Address wrap at the top of memory.
        chk_addr    = 1'b0;
        delay_min   = 0;
        delay_max   = 0;
        redirect_pc = 32'hFFFF_FFFA;
        redirect_en = 1'b1;
        cycle();
        p0 = pops;
        repeat (10) cycle();
        check("f_wrap_progress", (pops - p0) >= 4, 1);

        // Randomized traffic: bus latency/grant gaps, stalls, redirects, faults.
        rand_err  = 1'b1;
        gnt_pct   = 70;
        rv_pct    = 80;
        delay_max = 3;
        p0 = pops;
        for (int i = 0; i < 1500; i++) begin
            ready_id = ($urandom_range(3) != 0);
            stall_F  = ($urandom_range(4) == 0);
            if ($urandom_range(19) == 0) begin
                redirect_pc = $urandom;
                redirect_en = 1'b1;
            end
            cycle();
        end
        ready_id = 1'b1;
        stall_F  = 1'b0;
        repeat (20) cycle();
        check("g_random_progress", (pops - p0) >= 200, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage. Owns the fetch PC and drives the instruction-memory request/grant/rvalid bus.
- Buffers returned words in a small prefetch FIFO and presents {pc, instr, error} to the decode stage.
- Takes redirects (branch, jump, trap, mret) from downstream, then discards stale in-flight responses and restarts fetch at the new PC.

Parameters:
FIFO_DEPTH, 2, prefetch entries; also the maximum outstanding bus requests (credit limit); power of 2, ≥2
RESET_PC_ALIGN, 2, number of low PC bits forced to zero (word-aligned fetch)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
boot_addr  input  32  fetch address loaded at reset; quasi-static
instr_req  output  1  bus request
instr_addr  output  32  bus address, word-aligned
instr_gnt  input  1  bus accepted request this cycle
instr_rvalid  input  1  response valid; responses return in request order
instr_rdata  input  32  response data
instr_err  input  1  response error (PMP or bus), qualified by instr_rvalid
redirect_en  input  1  flow change from EX/WB, one-cycle pulse
redirect_pc  input  32  new fetch target
stall_F  input  1  hold: issue no new requests
ready_id  input  1  decode accepts the presented instruction this cycle
pc_id  output  32  PC of the presented instruction
instr_payload  output  32  presented instruction word
instr_value  output  1  presented instruction valid
instr_fetch_error  output  1  presented entry is a fetch fault

Behaviour:
- Reset (synchronous, highest priority):
  - fetch_pc <= boot_addr & ~3.
  - instr_req = 0; FIFO empty; outstanding = 0; discard = 0.
  - instr_value = 0, pc_id = 0, instr_payload = 0, instr_fetch_error = 0.
  - Reset mid-transaction abandons all in-flight responses; after reset the bench must not return responses for pre-reset requests.
- Credit rule: request issue is allowed iff outstanding + fifo_count < FIFO_DEPTH, ~stall_F, and ~redirect_en. This makes FIFO overflow impossible.
- Bus rule: once instr_req=1 with ~instr_gnt, instr_req and instr_addr hold stable until gnt, including across redirect and stall_F.
- Handshake: on req & gnt, outstanding++ and fetch_pc += 4. A new request may issue the next cycle, or the same cycle back-to-back if credit allows.
- Fetch-to-decode latency: earliest instr_value is the cycle after the rvalid that pushes the entry (FIFO is registered).
- Response path:
  - On rvalid, outstanding--.
  - If discard > 0, the response is dropped and discard--.
  - Otherwise push {pc, instr_rdata, instr_err}. The entry's pc is tracked by a response-PC register that advances +4 per accepted push.
  - On instr_err, payload = 32'h0 and err = 1. Fetch continues sequentially; decode raises the fault and a later redirect recovers.
- Output: instr_value = ~fifo_empty & ~redirect_en. pc_id, instr_payload and instr_fetch_error come from the FIFO head.
- Pop when instr_value & ready_id.
- Redirect (redirect_en=1):
  - FIFO cleared next cycle. fetch_pc and the response PC <= redirect_pc & ~3.
  - discard <= outstanding (after this cycle's gnt/rvalid updates) + the pending un-granted request if it is later granted.
  - Any un-granted request that is later granted is counted into discard at grant time.
  - Same-cycle cases:
    - rvalid during redirect: dropped.
    - gnt during redirect: that request is counted into discard.
    - pop during redirect: suppressed.
- Back-to-back redirects: the latest redirect wins; discard accumulates.
- stall_F does not block responses or pops, only new issue.
- Counter widths: $clog2(FIFO_DEPTH)+1 bits. discard ≤ FIFO_DEPTH; assertion on discard underflow or rvalid with outstanding=0.
- fetch_pc wraps modulo 2^32 (0xFFFFFFFC + 4 = 0).

Decomposition:
- riscv_pkg gains:
  - FETCH_FIFO_DEPTH constant.
  - fetch_entry_t packed struct {pc[31:0], instr[31:0], err}.
- Sub-module fetch_fifo: synchronous FIFO with push, pop, clear, full/empty, count. The clear input has priority over a same-cycle push.
- if_stage holds the PC, credit/discard counters, bus control and output mapping.

Test Plan:
1. Reset with boot_addr=0x8000_0002, zero-wait bus, gnt=1, rvalid one cycle after gnt, ready_id=1 → instr_addr sequence 0x8000_0000, _0004, _0008…; pc_id follows the same sequence; payload matches memory; instr_value continuous after fill.
2. ready_id=0 for 10 cycles → at most FIFO_DEPTH requests outstanding+buffered; no rvalid lost; pc_id holds 0x8000_0000 until ready_id=1, then stream resumes in order.
3. Redirect to 0x0000_1000 while 2 requests are outstanding → both responses dropped, FIFO emptied; next pc_id=0x0000_1000 with its payload; instr_value=0 during the redirect cycle.
4. instr_gnt=0 for 5 cycles with redirect in cycle 2 → instr_addr stays at the old address until gnt; that response is discarded; next request is 0x0000_1000.
5. instr_err=1 on the response for 0x8000_0008 → entry presented with instr_fetch_error=1, payload 0; following entry 0x8000_000C fetched normally.
6. Reset asserted with 1 outstanding and 1 buffered → next cycle instr_value=0 and instr_req=0; fetch restarts at boot_addr.
